// File: rtl/rd_pkg.sv
// Shared encodings for the rd writeback / operand-forwarding path.
package rd_pkg;

  localparam logic [1:0] SEL_PC4   = 2'b00;
  localparam logic [1:0] SEL_AUIPC = 2'b01;
  localparam logic [1:0] SEL_LUI   = 2'b10;
  localparam logic [1:0] SEL_ALU   = 2'b11;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

endpackage

// File: rtl/operand_fwd_lane.sv
// Single-operand forward resolution: MEM beats WB beats register file.
module operand_fwd_lane
  import rd_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned RADDR = 5
) (
  input  logic [RADDR-1:0] i_rs,
  input  logic [XLEN-1:0]  i_rf_data,
  input  logic             i_m_en,
  input  logic             i_m_load,
  input  logic [RADDR-1:0] i_m_rd,
  input  logic [XLEN-1:0]  i_m_val,
  input  logic             i_w_en,
  input  logic [RADDR-1:0] i_w_rd,
  input  logic [XLEN-1:0]  i_w_val,
  output logic [XLEN-1:0]  o_op,
  output logic [1:0]       o_fwd,
  output logic             o_load_hit
);

  logic w_rs_nz;
  logic w_m_hit;
  logic w_w_hit;

  assign w_rs_nz    = (i_rs != '0);
  assign w_m_hit    = w_rs_nz & i_m_en & (i_m_rd == i_rs);
  assign w_w_hit    = w_rs_nz & i_w_en & (i_w_rd == i_rs);
  assign o_load_hit = w_m_hit & i_m_load;

  // A load in MEM has no data yet, so the lane falls through to WB/regfile.
  always_comb begin
    o_op  = i_rf_data;
    o_fwd = FWD_RF;
    if (w_m_hit && !i_m_load) begin
      o_op  = i_m_val;
      o_fwd = FWD_MEM;
    end else if (w_w_hit) begin
      o_op  = i_w_val;
      o_fwd = FWD_WB;
    end
  end

endmodule

// File: rtl/rd_operand_forward.sv
// MEM/WB pipeline for rd results, register-file write port and ID operand forwarding.
module rd_operand_forward
  import rd_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned RADDR = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             advance,
  input  logic             flush,
  input  logic             ex_valid,
  input  logic             ex_regwrite,
  input  logic             ex_is_load,
  input  logic [RADDR-1:0] ex_rd,
  input  logic [1:0]       ex_sel,
  input  logic [XLEN-1:0]  ex_pc4,
  input  logic [XLEN-1:0]  ex_auipc,
  input  logic [XLEN-1:0]  ex_lui,
  input  logic [XLEN-1:0]  ex_alu,
  input  logic [XLEN-1:0]  mem_rdata,
  input  logic [RADDR-1:0] id_rs1,
  input  logic [RADDR-1:0] id_rs2,
  input  logic [XLEN-1:0]  rf_rs1_data,
  input  logic [XLEN-1:0]  rf_rs2_data,
  output logic [XLEN-1:0]  op1,
  output logic [XLEN-1:0]  op2,
  output logic [1:0]       fwd1,
  output logic [1:0]       fwd2,
  output logic             load_use_stall,
  output logic             wb_we,
  output logic [RADDR-1:0] wb_rd,
  output logic [XLEN-1:0]  wb_data
);

  logic             r_m_valid;
  logic             r_m_we;
  logic             r_m_load;
  logic [RADDR-1:0] r_m_rd;
  logic [XLEN-1:0]  r_m_val;

  logic             r_w_valid;
  logic             r_w_we;
  logic [RADDR-1:0] r_w_rd;
  logic [XLEN-1:0]  r_w_val;

  logic             w_ex_live;
  logic [XLEN-1:0]  w_ex_val;
  logic             w_m_en;
  logic             w_w_en;
  logic             w_load_hit1;
  logic             w_load_hit2;

  assign w_ex_live = ex_valid & ~flush;

  always_comb begin
    w_ex_val = ex_alu;
    case (ex_sel)
      SEL_PC4:   w_ex_val = ex_pc4;
      SEL_AUIPC: w_ex_val = ex_auipc;
      SEL_LUI:   w_ex_val = ex_lui;
      default:   w_ex_val = ex_alu;
    endcase
  end

  // Killed instructions enter MEM as clean bubbles so their rd never reaches wb_rd.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_valid <= 1'b0;
      r_m_we    <= 1'b0;
      r_m_load  <= 1'b0;
      r_m_rd    <= '0;
      r_m_val   <= '0;
    end else if (advance) begin
      r_m_valid <= w_ex_live;
      r_m_we    <= w_ex_live & ex_regwrite & (ex_rd != '0);
      r_m_load  <= w_ex_live & ex_is_load;
      r_m_rd    <= w_ex_live ? ex_rd : '0;
      r_m_val   <= w_ex_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_w_valid <= 1'b0;
      r_w_we    <= 1'b0;
      r_w_rd    <= '0;
      r_w_val   <= '0;
    end else if (advance) begin
      r_w_valid <= r_m_valid;
      r_w_we    <= r_m_we;
      r_w_rd    <= r_m_rd;
      r_w_val   <= r_m_load ? mem_rdata : r_m_val;
    end
  end

  assign w_m_en = r_m_valid & r_m_we;
  assign w_w_en = r_w_valid & r_w_we;

  operand_fwd_lane #(
    .XLEN  (XLEN),
    .RADDR (RADDR)
  ) u_lane_rs1 (
    .i_rs       (id_rs1),
    .i_rf_data  (rf_rs1_data),
    .i_m_en     (w_m_en),
    .i_m_load   (r_m_load),
    .i_m_rd     (r_m_rd),
    .i_m_val    (r_m_val),
    .i_w_en     (w_w_en),
    .i_w_rd     (r_w_rd),
    .i_w_val    (r_w_val),
    .o_op       (op1),
    .o_fwd      (fwd1),
    .o_load_hit (w_load_hit1)
  );

  operand_fwd_lane #(
    .XLEN  (XLEN),
    .RADDR (RADDR)
  ) u_lane_rs2 (
    .i_rs       (id_rs2),
    .i_rf_data  (rf_rs2_data),
    .i_m_en     (w_m_en),
    .i_m_load   (r_m_load),
    .i_m_rd     (r_m_rd),
    .i_m_val    (r_m_val),
    .i_w_en     (w_w_en),
    .i_w_rd     (r_w_rd),
    .i_w_val    (r_w_val),
    .o_op       (op2),
    .o_fwd      (fwd2),
    .o_load_hit (w_load_hit2)
  );

  assign load_use_stall = w_load_hit1 | w_load_hit2;
  assign wb_we          = w_w_en;
  assign wb_rd          = r_w_rd;
  assign wb_data        = r_w_val;

endmodule

// File: tb/tb_rd_operand_forward.sv
// Scoreboard bench: per-cycle expectations from a slot-level pipeline model, checked at negedge.
module tb_rd_operand_forward;

  logic        clk;
  logic        rst_n;
  logic        advance, flush, ex_valid, ex_regwrite, ex_is_load;
  logic [4:0]  ex_rd, id_rs1, id_rs2;
  logic [1:0]  ex_sel;
  logic [31:0] ex_pc4, ex_auipc, ex_lui, ex_alu, mem_rdata, rf_rs1_data, rf_rs2_data;
  logic [31:0] op1, op2, wb_data;
  logic [1:0]  fwd1, fwd2;
  logic        load_use_stall, wb_we;
  logic [4:0]  wb_rd;

  rd_operand_forward #(.XLEN(32), .RADDR(5)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .advance        (advance),
    .flush          (flush),
    .ex_valid       (ex_valid),
    .ex_regwrite    (ex_regwrite),
    .ex_is_load     (ex_is_load),
    .ex_rd          (ex_rd),
    .ex_sel         (ex_sel),
    .ex_pc4         (ex_pc4),
    .ex_auipc       (ex_auipc),
    .ex_lui         (ex_lui),
    .ex_alu         (ex_alu),
    .mem_rdata      (mem_rdata),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .rf_rs1_data    (rf_rs1_data),
    .rf_rs2_data    (rf_rs2_data),
    .op1            (op1),
    .op2            (op2),
    .fwd1           (fwd1),
    .fwd2           (fwd2),
    .load_use_stall (load_use_stall),
    .wb_we          (wb_we),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic adv, fl, ev, rw, ld;
    logic [4:0] rd, rs1, rs2;
    logic [1:0] sel;
    logic [31:0] pc4, auipc, lui, alu, rdata, rf1, rf2;
  } stim_t;

  // One in-flight instruction as seen by the consumer.
  typedef struct {
    logic valid, we, load;
    logic [4:0] rd;
    logic [31:0] val;
  } slot_t;

  typedef struct {
    logic [31:0] op1, op2, data;
    logic [1:0]  fwd1, fwd2;
    logic        stall, we;
    logic [4:0]  rd;
  } exp_t;

  slot_t mem_s, wb_s;
  exp_t  exp_q[$];
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic void clear_model();
    mem_s = '{valid: 1'b0, we: 1'b0, load: 1'b0, rd: 5'd0, val: 32'd0};
    wb_s  = mem_s;
  endfunction

  // Youngest producer first; a load still in MEM cannot supply data and is skipped.
  function automatic void resolve(input logic [4:0] rs, input logic [31:0] rf,
                                  output logic [31:0] op, output logic [1:0] fwd,
                                  output logic lstall);
    slot_t pipe[2];
    pipe[0] = mem_s;
    pipe[1] = wb_s;
    op = rf;
    fwd = 2'b00;
    lstall = 1'b0;
    if (rs != 5'd0) begin
      for (int k = 0; k < 2; k++) begin
        if (pipe[k].valid && pipe[k].we && pipe[k].rd == rs) begin
          if (k == 0 && pipe[k].load) begin
            lstall = 1'b1;
            continue;
          end
          op  = pipe[k].val;
          fwd = (k == 0) ? 2'b01 : 2'b10;
          break;
        end
      end
    end
  endfunction

  function automatic stim_t quiet();
    stim_t s;
    s = '{adv: 1'b0, fl: 1'b0, ev: 1'b0, rw: 1'b0, ld: 1'b0, rd: 5'd0, rs1: 5'd0, rs2: 5'd0,
          sel: 2'b11, pc4: 32'd0, auipc: 32'd0, lui: 32'd0, alu: 32'd0, rdata: 32'd0,
          rf1: 32'h0000_0055, rf2: 32'h0000_0066};
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.adv   = ($urandom_range(3) != 0);
    s.fl    = ($urandom_range(6) == 0);
    s.ev    = ($urandom_range(7) != 0);
    s.rw    = ($urandom_range(4) != 0);
    s.ld    = ($urandom_range(3) == 0);
    s.rd    = 5'($urandom_range(7));
    s.rs1   = 5'($urandom_range(7));
    s.rs2   = 5'($urandom_range(7));
    s.sel   = 2'($urandom_range(3));
    s.pc4   = $urandom;
    s.auipc = $urandom;
    s.lui   = $urandom;
    s.alu   = $urandom;
    s.rdata = $urandom;
    s.rf1   = $urandom;
    s.rf2   = $urandom;
    return s;
  endfunction

  // Drive one cycle's inputs at posedge+1, queue the expected outputs, then advance the model
  // to the state the next rising edge will produce.
  task automatic step(input stim_t s, input logic rst_val);
    logic [31:0] cand[4];
    logic s1, s2;
    exp_t e;
    slot_t nm;
    @(posedge clk);
    #1;
    advance = s.adv; flush = s.fl; ex_valid = s.ev; ex_regwrite = s.rw; ex_is_load = s.ld;
    ex_rd = s.rd; ex_sel = s.sel; ex_pc4 = s.pc4; ex_auipc = s.auipc; ex_lui = s.lui;
    ex_alu = s.alu; mem_rdata = s.rdata; id_rs1 = s.rs1; id_rs2 = s.rs2;
    rf_rs1_data = s.rf1; rf_rs2_data = s.rf2;
    rst_n = rst_val;
    if (!rst_val) clear_model();
    resolve(s.rs1, s.rf1, e.op1, e.fwd1, s1);
    resolve(s.rs2, s.rf2, e.op2, e.fwd2, s2);
    e.stall = s1 | s2;
    e.we    = wb_s.valid & wb_s.we;
    e.rd    = wb_s.rd;
    e.data  = wb_s.val;
    exp_q.push_back(e);
    if (rst_val && s.adv) begin
      cand = '{s.pc4, s.auipc, s.lui, s.alu};
      nm.valid = s.ev & ~s.fl;
      nm.we    = nm.valid & s.rw & (s.rd != 5'd0);
      nm.load  = nm.valid & s.ld;
      nm.rd    = nm.valid ? s.rd : 5'd0;
      nm.val   = cand[s.sel];
      wb_s.valid = mem_s.valid;
      wb_s.we    = mem_s.we;
      wb_s.rd    = mem_s.rd;
      wb_s.val   = mem_s.load ? s.rdata : mem_s.val;
      mem_s = nm;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("op1", op1, e.op1);
      chk("op2", op2, e.op2);
      chk("fwd1", 32'(fwd1), 32'(e.fwd1));
      chk("fwd2", 32'(fwd2), 32'(e.fwd2));
      chk("load_use_stall", 32'(load_use_stall), 32'(e.stall));
      chk("wb_we", 32'(wb_we), 32'(e.we));
      chk("wb_rd", 32'(wb_rd), 32'(e.rd));
      chk("wb_data", wb_data, e.data);
    end
  end

  initial begin
    stim_t s;
    int wait_cnt;
    rst_n = 1'b0;
    clear_model();
    s = quiet();
    advance = 0; flush = 0; ex_valid = 0; ex_regwrite = 0; ex_is_load = 0; ex_rd = 0;
    ex_sel = 0; ex_pc4 = 0; ex_auipc = 0; ex_lui = 0; ex_alu = 0; mem_rdata = 0;
    id_rs1 = 0; id_rs2 = 0; rf_rs1_data = 0; rf_rs2_data = 0;
    step(s, 1'b0);
    step(s, 1'b0);

    // 1: WB holds a write to x4, then an asynchronous reset mid-cycle.
    s = quiet(); s.adv = 1; s.ev = 1; s.rw = 1; s.rd = 5'd4; s.alu = 32'h0000_0400;
    step(s, 1'b1);
    s = quiet(); s.adv = 1;
    step(s, 1'b1);
    s = quiet(); s.rs1 = 5'd4;
    step(s, 1'b1);
    #1 chk("t1_pre_wb_we", 32'(wb_we), 32'd1);
    s = quiet(); s.rs1 = 5'd4; s.adv = 1;
    step(s, 1'b0);
    #1 chk("t1_wb_we", 32'(wb_we), 32'd0);
    chk("t1_op1", op1, 32'h0000_0055);
    chk("t1_fwd1", 32'(fwd1), 32'd0);
    s = quiet(); s.adv = 1;
    step(s, 1'b1);

    // 2: ALU result forwarded from MEM the next cycle.
    s = quiet(); s.adv = 1; s.ev = 1; s.rw = 1; s.rd = 5'd5; s.alu = 32'h0000_0010;
    step(s, 1'b1);
    s = quiet(); s.rs1 = 5'd5;
    step(s, 1'b1);
    #1 chk("t2_op1", op1, 32'h0000_0010);
    chk("t2_fwd1", 32'(fwd1), 32'd1);

    // 3: MEM beats WB for the same rd.
    s = quiet(); s.adv = 1; s.ev = 1; s.rw = 1; s.rd = 5'd7; s.sel = 2'b10;
    s.lui = 32'h1234_5000;
    step(s, 1'b1);
    s = quiet(); s.adv = 1; s.ev = 1; s.rw = 1; s.rd = 5'd7; s.sel = 2'b01;
    s.auipc = 32'h0000_1004;
    step(s, 1'b1);
    s = quiet(); s.rs2 = 5'd7;
    step(s, 1'b1);
    #1 chk("t3_op2_mem", op2, 32'h0000_1004);
    chk("t3_fwd2_mem", 32'(fwd2), 32'd1);
    chk("t3_wb_data_lui", wb_data, 32'h1234_5000);
    s = quiet(); s.rs2 = 5'd7; s.adv = 1; s.ev = 1; s.rw = 1; s.rd = 5'd12;
    step(s, 1'b1);
    s = quiet(); s.rs2 = 5'd7;
    step(s, 1'b1);
    #1 chk("t3_op2_wb", op2, 32'h0000_1004);
    chk("t3_fwd2_wb", 32'(fwd2), 32'd2);

    // 4: load-use stall, then load data forwarded from WB.
    s = quiet(); s.adv = 1; s.ev = 1; s.rw = 1; s.ld = 1; s.rd = 5'd3;
    step(s, 1'b1);
    s = quiet(); s.rs2 = 5'd3; s.rdata = 32'hDEAD_BEEF;
    step(s, 1'b1);
    #1 chk("t4_stall", 32'(load_use_stall), 32'd1);
    s = quiet(); s.rs2 = 5'd3; s.adv = 1; s.rdata = 32'hDEAD_BEEF;
    step(s, 1'b1);
    s = quiet(); s.rs2 = 5'd3;
    step(s, 1'b1);
    #1 chk("t4_stall_clr", 32'(load_use_stall), 32'd0);
    chk("t4_op2", op2, 32'hDEAD_BEEF);
    chk("t4_fwd2", 32'(fwd2), 32'd2);
    chk("t4_wb_we", 32'(wb_we), 32'd1);
    chk("t4_wb_rd", 32'(wb_rd), 32'd3);

    // 6a: three held cycles with noisy EX inputs, including flush.
    for (int i = 0; i < 3; i++) begin
      s = rand_stim(); s.adv = 0; s.fl = 1;
      step(s, 1'b1);
      #1 chk("t6_hold_rd", 32'(wb_rd), 32'd3);
      chk("t6_hold_data", wb_data, 32'hDEAD_BEEF);
    end

    // 5: writes to x0 never reach the write port.
    s = quiet(); s.adv = 1; s.ev = 1; s.rw = 1; s.rd = 5'd0; s.sel = 2'b00; s.pc4 = 32'h44;
    step(s, 1'b1);
    s = quiet(); s.adv = 1;
    step(s, 1'b1);
    s = quiet(); s.rf1 = 32'h0000_0077;
    step(s, 1'b1);
    #1 chk("t5_fwd1", 32'(fwd1), 32'd0);
    chk("t5_op1", op1, 32'h0000_0077);
    chk("t5_wb_we", 32'(wb_we), 32'd0);

    // 6b: flushed load to x9 never stalls, forwards or writes back.
    s = quiet(); s.adv = 1; s.fl = 1; s.ev = 1; s.rw = 1; s.ld = 1; s.rd = 5'd9;
    s.alu = 32'h99;
    step(s, 1'b1);
    for (int i = 0; i < 2; i++) begin
      s = quiet(); s.adv = 1; s.rs1 = 5'd9; s.rs2 = 5'd9;
      step(s, 1'b1);
      #1 chk("t6_fwd1", 32'(fwd1), 32'd0);
      chk("t6_stall", 32'(load_use_stall), 32'd0);
      chk("t6_wb_rd", 32'(wb_rd == 5'd9), 32'd0);
    end

    // Randomized traffic with an occasional asynchronous reset.
    for (int i = 0; i < 600; i++) begin
      s = rand_stim();
      step(s, ($urandom_range(99) != 0));
    end

    wait_cnt = 0;
    while (exp_q.size() != 0 && wait_cnt < 20) begin
      @(posedge clk);
      wait_cnt++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
